// File: rtl/pll_reset_sequencer.sv
// pll_reset_sequencer: staged reset release after a PLL reports stable lock.
// The PLL locked flag is synchronised and must stay high for a qualification
// window. All resets are then held for a fixed time, and the stages are
// released one at a time. Loss of lock or a soft request re-asserts every reset.
// Optional build macro PLL_RST_STATS_EN adds a saturating lock-loss event counter.
module pll_reset_sequencer #(
  parameter int SYNC_STAGES        = 2,
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int RST_HOLD_CYCLES    = 16,
  parameter int NUM_STAGES         = 3,
  parameter int STAGE_GAP          = 8,
  parameter int CNT_W              = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  locked,
  input  logic                  soft_rst_req,
  input  logic                  clr_stats,
  output logic [NUM_STAGES-1:0] rst_stage_out,
  output logic                  ready,
  output logic [2:0]            state_o,
  output logic                  lock_lost_sticky,
  output logic [CNT_W-1:0]      lock_loss_cnt
);

  typedef enum logic [2:0] {
    WAIT_LOCK = 3'd0,
    QUALIFY   = 3'd1,
    HOLD      = 3'd2,
    RELEASE   = 3'd3,
    RUN       = 3'd4
  } state_t;

  // The cycle counter only has to reach the largest window minus one.
  localparam int MAX_AB  = (LOCK_STABLE_CYCLES > RST_HOLD_CYCLES) ? LOCK_STABLE_CYCLES : RST_HOLD_CYCLES;
  localparam int MAX_CYC = (MAX_AB > STAGE_GAP) ? MAX_AB : STAGE_GAP;
  localparam int CW      = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int IW      = $clog2(NUM_STAGES + 1);

  localparam logic [CW-1:0] LOCK_LAST = CW'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CW-1:0] HOLD_LAST = CW'(RST_HOLD_CYCLES - 1);
  localparam logic [CW-1:0] GAP_LAST  = CW'(STAGE_GAP - 1);
  localparam logic [IW-1:0] IDX_END   = IW'(NUM_STAGES);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   locked_s;

  state_t                 state, state_n;
  logic [CW-1:0]          cnt, cnt_n;
  logic [IW-1:0]          idx, idx_n;
  logic [NUM_STAGES-1:0]  stage_n;
  logic                   ready_n;
  logic                   sticky_n;
  logic                   lock_event;
  logic                   active;

  // Locked synchroniser: the only logic that looks at the raw locked input.
  always_ff @(posedge clk) begin
    if (rst) sync_q <= '0;
    else     sync_q <= {sync_q[SYNC_STAGES-2:0], locked};
  end

  assign locked_s = sync_q[SYNC_STAGES-1];
  assign active   = (state == HOLD) || (state == RELEASE) || (state == RUN);
  assign state_o  = state;

  // Next-state and next-output logic; lock loss outranks a soft request.
  always_comb begin
    // NOTE: every signal written here gets a default first so no latch is inferred.
    state_n    = state;
    cnt_n      = cnt;
    idx_n      = idx;
    stage_n    = rst_stage_out;
    ready_n    = ready;
    lock_event = 1'b0;

    if (active && !locked_s) begin
      state_n    = WAIT_LOCK;
      cnt_n      = '0;
      stage_n    = '1;
      ready_n    = 1'b0;
      lock_event = 1'b1;
    end else if (active && soft_rst_req) begin
      state_n = HOLD;
      cnt_n   = '0;
      stage_n = '1;
      ready_n = 1'b0;
    end else begin
      case (state)
        WAIT_LOCK: begin
          stage_n = '1;
          ready_n = 1'b0;
          if (locked_s) begin
            state_n = QUALIFY;
            cnt_n   = '0;
          end
        end
        QUALIFY: begin
          if (!locked_s) begin
            state_n = WAIT_LOCK;
          end else if (cnt == LOCK_LAST) begin
            state_n = HOLD;
            cnt_n   = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        HOLD: begin
          if (cnt == HOLD_LAST) begin
            state_n    = RELEASE;
            cnt_n      = '0;
            idx_n      = IW'(1);
            stage_n[0] = 1'b0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        RELEASE: begin
          if (idx == IDX_END) begin
            state_n = RUN;
            ready_n = 1'b1;
          end else if (cnt == GAP_LAST) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
              if (IW'(k) == idx) stage_n[k] = 1'b0;
            end
            idx_n = idx + IW'(1);
            cnt_n = '0;
          end else begin
            cnt_n = cnt + CW'(1);
          end
        end
        RUN: begin
          ready_n = 1'b1;
        end
        default: begin
          state_n = WAIT_LOCK;
          stage_n = '1;
          ready_n = 1'b0;
        end
      endcase
    end

    // A lock-loss event in the same cycle as a clear leaves the flag set.
    sticky_n = lock_event | (lock_lost_sticky & ~clr_stats);
  end

  // FSM state, counters and registered outputs.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    if (rst) begin
      state            <= WAIT_LOCK;
      cnt              <= '0;
      idx              <= '0;
      rst_stage_out    <= '1;
      ready            <= 1'b0;
      lock_lost_sticky <= 1'b0;
    end else begin
      state            <= state_n;
      cnt              <= cnt_n;
      idx              <= idx_n;
      rst_stage_out    <= stage_n;
      ready            <= ready_n;
      lock_lost_sticky <= sticky_n;
    end
  end

`ifdef PLL_RST_STATS_EN
  logic [CNT_W-1:0] loss_cnt_n;

  // Saturating lock-loss counter; an event in a clear cycle counts from zero.
  always_comb begin
    loss_cnt_n = clr_stats ? '0 : lock_loss_cnt;
    if (lock_event && (loss_cnt_n != '1)) loss_cnt_n = loss_cnt_n + CNT_W'(1);
  end

  // Lock-loss counter register.
  always_ff @(posedge clk) begin
    if (rst) lock_loss_cnt <= '0;
    else     lock_loss_cnt <= loss_cnt_n;
  end
`else
  assign lock_loss_cnt = '0;
`endif

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// Directed bench for pll_reset_sequencer: reset state, clean and glitchy lock
// timelines, lock loss, soft re-sequence, simultaneous events, counter
// saturation and clear, and reset during RELEASE.
module tb_pll_reset_sequencer;

  localparam int SS   = 2;
  localparam int LSC  = 8;
  localparam int RHC  = 4;
  localparam int NS   = 3;
  localparam int GAP  = 2;
  localparam int CW   = 2;

  logic          clk = 1'b0;
  logic          rst;
  logic          locked;
  logic          soft_rst_req;
  logic          clr_stats;
  logic [NS-1:0] rst_stage_out;
  logic          ready;
  logic [2:0]    state_o;
  logic          lock_lost_sticky;
  logic [CW-1:0] lock_loss_cnt;

  int n_cmp  = 0;
  int n_fail = 0;

  pll_reset_sequencer #(
    .SYNC_STAGES       (SS),
    .LOCK_STABLE_CYCLES(LSC),
    .RST_HOLD_CYCLES   (RHC),
    .NUM_STAGES        (NS),
    .STAGE_GAP         (GAP),
    .CNT_W             (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .locked          (locked),
    .soft_rst_req    (soft_rst_req),
    .clr_stats       (clr_stats),
    .rst_stage_out   (rst_stage_out),
    .ready           (ready),
    .state_o         (state_o),
    .lock_lost_sticky(lock_lost_sticky),
    .lock_loss_cnt   (lock_loss_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  // Expected lock-loss count after n events with a 2-bit saturating counter.
  function automatic logic [31:0] exp_cnt(input int n);
`ifdef PLL_RST_STATS_EN
    return (n > 3) ? 32'd3 : 32'(n);
`else
    return (n > 0) ? 32'd0 : 32'd0;
`endif
  endfunction

  // Outputs expected t cycles after the first QUALIFY cycle.
  task automatic check_timeline(input string tag, input int t);
    logic [NS-1:0] es;
    logic [2:0]    est;
    for (int k = 0; k < NS; k++) es[k] = (t < LSC + RHC + k * GAP);
    if (t < LSC)                             est = 3'd1;
    else if (t < LSC + RHC)                  est = 3'd2;
    else if (t < LSC + RHC + (NS-1)*GAP + 1) est = 3'd3;
    else                                     est = 3'd4;
    check($sformatf("%s stages Q+%0d", tag, t), rst_stage_out, es);
    check($sformatf("%s state Q+%0d", tag, t), state_o, est);
    check($sformatf("%s ready Q+%0d", tag, t), ready, (t >= LSC + RHC + (NS-1)*GAP + 1));
  endtask

  task automatic wait_state(input string tag, input logic [2:0] target);
    int i = 0;
    while (state_o !== target && i < 80) begin
      tick();
      i++;
    end
    check({tag, " reach state"}, state_o, target);
  endtask

  // Drop lock and advance to the cycle where the FSM has reacted to it.
  task automatic drop_lock(input logic clr_on_event);
    locked = 1'b0;
    tick();
    tick();
    clr_stats = clr_on_event;
    tick();
    clr_stats = 1'b0;
  endtask

  initial begin
    rst = 1'b1; locked = 1'b0; soft_rst_req = 1'b0; clr_stats = 1'b0;
    ticks(3);

    // Reset state
    check("rst state",  state_o, 0);
    check("rst stages", rst_stage_out, 3'b111);
    check("rst ready",  ready, 0);
    check("rst sticky", lock_lost_sticky, 0);
    check("rst cnt",    lock_loss_cnt, 0);

    // 1. Clean lock
    rst = 1'b0; locked = 1'b1;
    ticks(2);
    check("t1 pre-Q state", state_o, 0);
    tick();
    check("t1 Q state", state_o, 1);
    for (int t = 1; t <= 17; t++) begin
      tick();
      check_timeline("t1", t);
    end

    // 3. Lock loss in RUN
    locked = 1'b0;
    ticks(2);
    check("t3 still run", state_o, 4);
    check("t3 still ready", ready, 1);
    tick();
    check("t3 state",  state_o, 0);
    check("t3 stages", rst_stage_out, 3'b111);
    check("t3 ready",  ready, 0);
    check("t3 sticky", lock_lost_sticky, 1);
    check("t3 cnt",    lock_loss_cnt, exp_cnt(1));

    // 2. Glitchy lock after a fresh reset
    rst = 1'b1;
    ticks(2);
    check("t2 rst sticky", lock_lost_sticky, 0);
    check("t2 rst cnt", lock_loss_cnt, 0);
    rst = 1'b0; locked = 1'b1;
    ticks(5);
    locked = 1'b0;
    tick();
    locked = 1'b1;
    tick();
    check("t2 qualify before drop", state_o, 1);
    tick();
    check("t2 back to wait", state_o, 0);
    check("t2 sticky", lock_lost_sticky, 0);
    check("t2 cnt", lock_loss_cnt, 0);
    tick();
    check("t2 new Q state", state_o, 1);
    for (int t = 1; t <= 17; t++) begin
      tick();
      check_timeline("t2", t);
    end

    // 4. Soft request in RUN
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("t4 stages", rst_stage_out, 3'b111);
    check("t4 state", state_o, 2);
    check("t4 ready", ready, 0);
    ticks(3);
    check("t4 hold end stages", rst_stage_out, 3'b111);
    tick();
    check("t4 stage0 rel", rst_stage_out, 3'b110);
    check("t4 release state", state_o, 3);
    check("t4 cnt", lock_loss_cnt, 0);
    check("t4 sticky", lock_lost_sticky, 0);

    // 5. Lock loss and soft request together in RELEASE
    locked = 1'b0;
    tick();
    check("t5 release", state_o, 3);
    tick();
    check("t5 stage1 rel", rst_stage_out, 3'b100);
    soft_rst_req = 1'b1;
    tick();
    soft_rst_req = 1'b0;
    check("t5 state", state_o, 0);
    check("t5 stages", rst_stage_out, 3'b111);
    check("t5 ready", ready, 0);
    check("t5 sticky", lock_lost_sticky, 1);
    check("t5 cnt", lock_loss_cnt, exp_cnt(1));

    // 6. Saturation, clear, clear-with-event, reset mid-RELEASE
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("t6 clr cnt", lock_loss_cnt, 0);
    check("t6 clr sticky", lock_lost_sticky, 0);
    for (int n = 1; n <= 5; n++) begin
      locked = 1'b1;
      wait_state($sformatf("t6 loss%0d", n), 3'd4);
      drop_lock(1'b0);
      check($sformatf("t6 loss%0d state", n), state_o, 0);
      check($sformatf("t6 loss%0d cnt", n), lock_loss_cnt, exp_cnt(n));
    end
    clr_stats = 1'b1;
    tick();
    clr_stats = 1'b0;
    check("t6 clr2 cnt", lock_loss_cnt, 0);
    check("t6 clr2 sticky", lock_lost_sticky, 0);
    locked = 1'b1;
    wait_state("t6 clr+event", 3'd4);
    drop_lock(1'b1);
    check("t6 clr+event cnt", lock_loss_cnt, exp_cnt(1));
    check("t6 clr+event sticky", lock_lost_sticky, 1);
    locked = 1'b1;
    wait_state("t6 mid release", 3'd3);
    rst = 1'b1;
    tick();
    check("t6 rst state", state_o, 0);
    check("t6 rst stages", rst_stage_out, 3'b111);
    check("t6 rst ready", ready, 0);
    check("t6 rst sticky", lock_lost_sticky, 0);
    check("t6 rst cnt", lock_loss_cnt, 0);
    rst = 1'b0;
    ticks(2);
    check("t6 sync cleared", state_o, 0);
    tick();
    check("t6 requalify", state_o, 1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
